// File: rtl/capture_logger_pkg.sv
// Shared types and defaults for the multi-source capture logger.
package capture_logger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int CL_N_SRC     = 4;
  localparam int CL_RAM_DEPTH = 32768;
  localparam int CL_AW        = $clog2(CL_RAM_DEPTH);

  // The snapshot path sits one past the last streaming source.
  function automatic int snap_src_idx(input int n_src);
    return n_src;
  endfunction

endpackage

// File: rtl/block_ram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module block_ram #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32768,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [RAM_WIDTH-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [RAM_WIDTH-1:0] o_rd_data
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] rd_data_q;

  always_ff @(posedge i_clock) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge i_clock) begin
    if (i_reset)      rd_data_q <= '0;
    else if (i_rd_en) rd_data_q <= mem[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/coeff_snapshot_serializer.sv
// Periodically latches all equaliser taps and emits them one sign-extended word per cycle.
module coeff_snapshot_serializer
  import capture_logger_pkg::*;
#(
  parameter int RAM_WIDTH   = 32,
  parameter int NUM_TAPS    = 9,
  parameter int NBT_TAPS    = 10,
  parameter int SNAP_PERIOD = 250
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_clear,
  input  logic                         i_enable,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_coeff,
  output logic                         o_valid,
  output logic [RAM_WIDTH-1:0]         o_data,
  output logic                         o_last
);

  localparam int CW = (SNAP_PERIOD > 1) ? $clog2(SNAP_PERIOD) : 1;
  localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic [CW-1:0]                         cnt_q;
  logic [TW-1:0]                         idx_q;
  logic                                  act_q;
  logic [NUM_TAPS-1:0][NBT_TAPS-1:0]     taps_q;
  logic [NBT_TAPS-1:0]                   tap_sel;

  // SNAP_PERIOD > NUM_TAPS, so a burst always ends before the next latch.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      act_q  <= 1'b0;
      taps_q <= '0;
    end else if (!i_enable) begin
      act_q <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CW'(SNAP_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
      if (cnt_q == CW'(SNAP_PERIOD - 1)) begin
        taps_q <= i_coeff;
        idx_q  <= '0;
        act_q  <= 1'b1;
      end else if (act_q) begin
        if (idx_q == TW'(NUM_TAPS - 1)) act_q <= 1'b0;
        else                            idx_q <= idx_q + TW'(1);
      end
    end
  end

  assign tap_sel = taps_q[idx_q];
  assign o_valid = act_q;
  assign o_data  = {{(RAM_WIDTH - NBT_TAPS){tap_sel[NBT_TAPS-1]}}, tap_sel};
  assign o_last  = act_q && (idx_q == TW'(NUM_TAPS - 1));

endmodule

// File: rtl/multi_src_capture_logger.sv
// Captures one of N_SRC streams or periodic tap snapshots into block RAM for host read-back.
// Define LOG_CIRCULAR_EN for a wrapping capture buffer that ends only on i_stop.
module multi_src_capture_logger
  import capture_logger_pkg::*;
#(
  parameter int N_SRC       = CL_N_SRC,
  parameter int RAM_WIDTH   = 32,
  parameter int RAM_DEPTH   = CL_RAM_DEPTH,
  parameter int CAPTURE_LEN = 32000,
  parameter int NUM_TAPS    = 9,
  parameter int NBT_TAPS    = 10,
  parameter int SNAP_PERIOD = 250,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int SW = $clog2(N_SRC + 1)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [SW-1:0]                i_src_sel,
  input  logic [N_SRC*RAM_WIDTH-1:0]   i_src_data,
  input  logic [N_SRC-1:0]             i_src_valid,
  input  logic [NUM_TAPS*NBT_TAPS-1:0] i_coeff,
  input  logic                         i_rd_en,
  input  logic [AW-1:0]                i_rd_addr,
  output logic [RAM_WIDTH-1:0]         o_rd_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [AW:0]                  o_wr_count,
  output logic [AW-1:0]                o_wr_ptr
);

  localparam logic [SW-1:0] SNAP_SEL = SW'(snap_src_idx(N_SRC));
  localparam logic [AW:0]   CLEN     = (AW+1)'(CAPTURE_LEN);
  localparam logic [AW-1:0] LAST_PTR = AW'(CAPTURE_LEN - 1);

  state_t         state_q;
  logic [SW-1:0]  sel_q;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    wr_count_q, wr_count_d;
  logic           busy_q, done_q;

  logic                 capturing, snap_mode, start_acc, wr_en, last_wr;
  logic                 src_hit, snap_valid;
  logic [RAM_WIDTH-1:0] src_word, snap_data, wr_data;

  assign capturing = (state_q == CAPTURE);
  assign snap_mode = (sel_q == SNAP_SEL);
  assign start_acc = i_start && !capturing;

  // Out-of-range selects match no source and never write.
  always_comb begin
    src_hit  = 1'b0;
    src_word = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel_q == SW'(k)) begin
        src_hit  = i_src_valid[k];
        src_word = i_src_data[k*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  assign wr_en   = capturing && (snap_mode ? snap_valid : src_hit);
  assign wr_data = snap_mode ? snap_data : src_word;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    if (wr_en) begin
`ifdef LOG_CIRCULAR_EN
      wr_ptr_d   = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
      wr_count_d = (wr_count_q == CLEN) ? CLEN : wr_count_q + (AW+1)'(1);
`else
      wr_ptr_d   = wr_ptr_q + AW'(1);
      wr_count_d = wr_count_q + (AW+1)'(1);
`endif
    end
  end

`ifdef LOG_CIRCULAR_EN
  assign last_wr = 1'b0;
`else
  assign last_wr = wr_en && (wr_count_d == CLEN);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            state_q    <= CAPTURE;
            sel_q      <= i_src_sel;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        CAPTURE: begin
          wr_ptr_q   <= wr_ptr_d;
          wr_count_q <= wr_count_d;
          if (i_stop || last_wr) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  coeff_snapshot_serializer #(
    .RAM_WIDTH  (RAM_WIDTH),
    .NUM_TAPS   (NUM_TAPS),
    .NBT_TAPS   (NBT_TAPS),
    .SNAP_PERIOD(SNAP_PERIOD)
  ) u_snap (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (start_acc),
    .i_enable(capturing && snap_mode),
    .i_coeff (i_coeff),
    .o_valid (snap_valid),
    .o_data  (snap_data),
    .o_last  ()
  );

  block_ram #(
    .RAM_WIDTH(RAM_WIDTH),
    .RAM_DEPTH(RAM_DEPTH)
  ) u_ram (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_ptr_q),
    .i_wr_data(wr_data),
    .i_rd_en  (i_rd_en && !capturing),
    .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data)
  );

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_wr_count = wr_count_q;
  assign o_wr_ptr   = wr_ptr_q;

endmodule
